// File: rtl/udmon_pkg.sv
// udmon_pkg -- shared types and constants for the up/down counter monitor.
//   udmon_state_e : monitor tracking state (UNSYNC / ACQUIRE / LOCKED)
//   udmon_step_e  : classification of one observed count step
//   ERR_CNT_W     : width of the saturating error counter
//   RUN_W         : width of the consecutive-good-step counter (LOCK_N <= 15)
package udmon_pkg;

  localparam int ERR_CNT_W = 8;
  localparam int RUN_W     = 4;

  typedef enum logic [1:0] {
    UNSYNC  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } udmon_state_e;

  typedef enum logic [1:0] {
    UP      = 2'd0,
    DOWN    = 2'd1,
    HOLD    = 2'd2,
    ILLEGAL = 2'd3
  } udmon_step_e;

  // Saturating increment of the error counter; it sticks at all-ones.
  function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] v);
    logic [ERR_CNT_W-1:0] res;
    if (v == {ERR_CNT_W{1'b1}}) begin
      res = v;
    end else begin
      res = v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/udmon_step_classify.sv
// udmon_step_classify -- combinational classification of one counter step.
// Ports:
//   i_prev  [WIDTH] : count value captured on the previous edge
//   i_count [WIDTH] : current count value
//   o_step          : UP (+1), DOWN (-1), HOLD (0) or ILLEGAL (anything else)
//   o_wrap          : step crossed the max<->0 boundary (legal steps only)
// With WIDTH=1, +1 and -1 are the same delta; it is reported as UP and the
// parent resolves the direction.
module udmon_step_classify
  import udmon_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_prev,
  input  logic [WIDTH-1:0] i_count,
  output udmon_step_e      o_step,
  output logic             o_wrap
);

  logic [WIDTH-1:0] w_delta;
  logic [WIDTH-1:0] w_one;
  logic [WIDTH-1:0] w_max;
  logic [WIDTH-1:0] w_zero;

  assign w_delta = i_count - i_prev;
  assign w_one   = WIDTH'(1'b1);
  assign w_max   = {WIDTH{1'b1}};
  assign w_zero  = {WIDTH{1'b0}};

  // Decode the modular delta into a step class and flag boundary crossings.
  always_comb begin
    o_step = ILLEGAL;
    o_wrap = 1'b0;
    if (w_delta == w_one) begin
      o_step = UP;
      o_wrap = (i_count == w_zero);
    end else if (w_delta == w_max) begin
      o_step = DOWN;
      o_wrap = (i_count == w_max);
    end else if (w_delta == w_zero) begin
      o_step = HOLD;
      o_wrap = 1'b0;
    end else begin
      o_step = ILLEGAL;
      o_wrap = 1'b0;
    end
  end

endmodule

// File: rtl/updown_count_monitor.sv
// updown_count_monitor -- watches an up/down counter and its direction command,
// classifies each step, and reports lock and error status.
// Ports:
//   clk, reset (async active-low)
//   count_in [WIDTH] : observed counter value;  upordown : 1=up, 0=down command
//   dir_up / dir_down : direction of the last classified step
//   wrap, step_err, dir_err : one-cycle event pulses
//   locked : LOCK_N consecutive conforming steps seen;  err_cnt [8] : saturating
// Build option: UDMON_STRICT_STEP_EN -- when defined, a hold (no change) while
// tracking counts as an illegal step instead of a legal stall.
module updown_count_monitor
  import udmon_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 upordown,
  output logic                 dir_up,
  output logic                 dir_down,
  output logic                 wrap,
  output logic                 step_err,
  output logic                 dir_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  udmon_state_e         r_state;
  logic [RUN_W-1:0]     r_run;
  logic [WIDTH-1:0]     r_prev;
  logic                 r_dir_q;
  logic                 r_dir_up;
  logic                 r_dir_down;
  logic                 r_wrap;
  logic                 r_step_err;
  logic                 r_dir_err;
  logic                 r_locked;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  udmon_state_e         w_state_nxt;
  logic [RUN_W-1:0]     w_run_nxt;
  logic [RUN_W-1:0]     w_run_inc;
  logic                 w_dir_up_nxt;
  logic                 w_dir_down_nxt;
  logic                 w_wrap_nxt;
  logic                 w_step_err_nxt;
  logic                 w_dir_err_nxt;
  logic                 w_locked_nxt;
  logic [ERR_CNT_W-1:0] w_err_cnt_nxt;
  udmon_step_e          w_step;
  logic                 w_step_wrap;
  logic                 w_obs_up;
  logic                 w_obs_down;
  logic                 w_match;
  logic                 w_hold_bad;

  udmon_step_classify #(.WIDTH(WIDTH)) u_classify (
    .i_prev  (r_prev),
    .i_count (count_in),
    .o_step  (w_step),
    .o_wrap  (w_step_wrap)
  );

  // A 1-bit counter cannot tell +1 from -1, so the step is taken as the
  // commanded direction. The command is compared one edge late (r_dir_q)
  // because the observed counter reacts one edge after upordown changes.
  assign w_obs_up   = (WIDTH == 1) ? r_dir_q  : (w_step == UP);
  assign w_obs_down = (WIDTH == 1) ? ~r_dir_q : (w_step == DOWN);
  assign w_match    = (w_obs_up == r_dir_q);
  assign w_run_inc  = (r_run >= RUN_W'(LOCK_N)) ? r_run : r_run + RUN_W'(1'b1);

`ifdef UDMON_STRICT_STEP_EN
  assign w_hold_bad = (w_step == HOLD);
`else
  assign w_hold_bad = 1'b0;
`endif

  // Next-state and next-output decode for the tracking FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_run_nxt      = r_run;
    w_dir_up_nxt   = r_dir_up;
    w_dir_down_nxt = r_dir_down;
    w_wrap_nxt     = 1'b0;
    w_step_err_nxt = 1'b0;
    w_dir_err_nxt  = 1'b0;
    w_locked_nxt   = r_locked;
    w_err_cnt_nxt  = r_err_cnt;
    case (r_state)
      UNSYNC: begin
        // Only capture prev on this edge; nothing valid to compare against.
        w_state_nxt  = ACQUIRE;
        w_run_nxt    = {RUN_W{1'b0}};
        w_locked_nxt = 1'b0;
      end
      ACQUIRE, LOCKED: begin
        if ((w_step == ILLEGAL) || w_hold_bad) begin
          w_step_err_nxt = 1'b1;
          w_dir_up_nxt   = 1'b0;
          w_dir_down_nxt = 1'b0;
          w_state_nxt    = ACQUIRE;
          w_run_nxt      = {RUN_W{1'b0}};
          w_locked_nxt   = 1'b0;
          w_err_cnt_nxt  = err_sat_inc(r_err_cnt);
        end else if (w_step == HOLD) begin
          // Legal stall: keep everything as it was.
          w_state_nxt = r_state;
        end else if (w_match) begin
          w_dir_up_nxt   = w_obs_up;
          w_dir_down_nxt = w_obs_down;
          w_wrap_nxt     = w_step_wrap;
          w_run_nxt      = w_run_inc;
          if (w_run_inc >= RUN_W'(LOCK_N)) begin
            w_state_nxt  = LOCKED;
            w_locked_nxt = 1'b1;
          end else begin
            w_state_nxt  = ACQUIRE;
            w_locked_nxt = 1'b0;
          end
        end else begin
          w_dir_err_nxt  = 1'b1;
          w_dir_up_nxt   = w_obs_up;
          w_dir_down_nxt = w_obs_down;
          w_wrap_nxt     = w_step_wrap;
          w_state_nxt    = ACQUIRE;
          w_run_nxt      = {RUN_W{1'b0}};
          w_locked_nxt   = 1'b0;
          w_err_cnt_nxt  = err_sat_inc(r_err_cnt);
        end
      end
      default: begin
        w_state_nxt  = UNSYNC;
        w_run_nxt    = {RUN_W{1'b0}};
        w_locked_nxt = 1'b0;
      end
    endcase
  end

  // State, history and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= UNSYNC;
      r_run      <= {RUN_W{1'b0}};
      r_prev     <= {WIDTH{1'b0}};
      r_dir_q    <= 1'b0;
      r_dir_up   <= 1'b0;
      r_dir_down <= 1'b0;
      r_wrap     <= 1'b0;
      r_step_err <= 1'b0;
      r_dir_err  <= 1'b0;
      r_locked   <= 1'b0;
      r_err_cnt  <= {ERR_CNT_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_run      <= w_run_nxt;
      r_prev     <= count_in;
      r_dir_q    <= upordown;
      r_dir_up   <= w_dir_up_nxt;
      r_dir_down <= w_dir_down_nxt;
      r_wrap     <= w_wrap_nxt;
      r_step_err <= w_step_err_nxt;
      r_dir_err  <= w_dir_err_nxt;
      r_locked   <= w_locked_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
    end
  end

  assign dir_up   = r_dir_up;
  assign dir_down = r_dir_down;
  assign wrap     = r_wrap;
  assign step_err = r_step_err;
  assign dir_err  = r_dir_err;
  assign locked   = r_locked;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_updown_count_monitor.sv
module tb_updown_count_monitor;

  logic       clk;
  logic       reset;
  logic [3:0] count_in;
  logic       upordown;
  logic       dir_up;
  logic       dir_down;
  logic       wrap;
  logic       step_err;
  logic       dir_err;
  logic       locked;
  logic [7:0] err_cnt;

  int n_tests;
  int n_fail;

  updown_count_monitor #(.WIDTH(4), .LOCK_N(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .count_in (count_in),
    .upordown (upordown),
    .dir_up   (dir_up),
    .dir_down (dir_down),
    .wrap     (wrap),
    .step_err (step_err),
    .dir_err  (dir_err),
    .locked   (locked),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one count/command pair and settle just after the rising edge.
  task automatic drive(input logic [3:0] c, input logic d);
    @(negedge clk);
    count_in = c;
    upordown = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; count_in = 4'd0; upordown = 1'b1;
    #3;
    n_tests++;
    if ({dir_up, dir_down, wrap, step_err, dir_err, locked, err_cnt} !== 14'd0) begin
      n_fail++; $display("FAIL reset_async: outputs=%h expected=0", {dir_up, dir_down, wrap, step_err, dir_err, locked, err_cnt});
    end
    @(posedge clk); @(posedge clk); #1;
    n_tests++;
    if ({dir_up, dir_down, wrap, step_err, dir_err, locked, err_cnt} !== 14'd0) begin
      n_fail++; $display("FAIL reset_hold: outputs=%h expected=0", {dir_up, dir_down, wrap, step_err, dir_err, locked, err_cnt});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_lock();
    drive(4'd0, 1'b1);
    n_tests++;
    if (locked !== 1'b0 || dir_up !== 1'b0) begin
      n_fail++; $display("FAIL lock_unsync: locked=%b dir_up=%b expected 0 0", locked, dir_up);
    end
    drive(4'd1, 1'b1); drive(4'd2, 1'b1); drive(4'd3, 1'b1);
    n_tests++;
    if (locked !== 1'b0) begin
      n_fail++; $display("FAIL lock_early: locked=%b expected=0", locked);
    end
    drive(4'd4, 1'b1);
    n_tests++;
    if (locked !== 1'b1 || dir_up !== 1'b1 || dir_down !== 1'b0 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL lock_rise: locked=%b dir_up=%b dir_down=%b err_cnt=%0d expected 1 1 0 0", locked, dir_up, dir_down, err_cnt);
    end
    drive(4'd5, 1'b1);
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL lock_hold: locked=%b expected=1", locked);
    end
  endtask

  task automatic test_wrap();
    for (int c = 6; c <= 15; c++) drive(4'(c), 1'b1);
    n_tests++;
    if (wrap !== 1'b0) begin
      n_fail++; $display("FAIL wrap_early: wrap=%b expected=0", wrap);
    end
    drive(4'd0, 1'b1);
    n_tests++;
    if (wrap !== 1'b1 || locked !== 1'b1 || step_err !== 1'b0 || dir_err !== 1'b0) begin
      n_fail++; $display("FAIL wrap_pulse: wrap=%b locked=%b step_err=%b dir_err=%b expected 1 1 0 0", wrap, locked, step_err, dir_err);
    end
    drive(4'd1, 1'b1);
    n_tests++;
    if (wrap !== 1'b0 || locked !== 1'b1 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL wrap_end: wrap=%b locked=%b err_cnt=%0d expected 0 1 0", wrap, locked, err_cnt);
    end
  endtask

  task automatic test_dir();
    for (int c = 2; c <= 7; c++) drive(4'(c), 1'b1);
    // Command turns down on the same edge the counter still steps up.
    drive(4'd8, 1'b0);
    n_tests++;
    if (dir_err !== 1'b0 || dir_up !== 1'b1) begin
      n_fail++; $display("FAIL dir_latency: dir_err=%b dir_up=%b expected 0 1", dir_err, dir_up);
    end
    drive(4'd7, 1'b0);
    n_tests++;
    if (dir_down !== 1'b1 || dir_up !== 1'b0 || dir_err !== 1'b0 || locked !== 1'b1) begin
      n_fail++; $display("FAIL dir_down: dir_down=%b dir_up=%b dir_err=%b locked=%b expected 1 0 0 1", dir_down, dir_up, dir_err, locked);
    end
    drive(4'd8, 1'b0);
    n_tests++;
    if (dir_err !== 1'b1 || dir_up !== 1'b1 || step_err !== 1'b0 || err_cnt !== 8'd1 || locked !== 1'b0) begin
      n_fail++; $display("FAIL dir_err: dir_err=%b dir_up=%b step_err=%b err_cnt=%0d locked=%b expected 1 1 0 1 0", dir_err, dir_up, step_err, err_cnt, locked);
    end
    drive(4'd7, 1'b0);
    n_tests++;
    if (dir_err !== 1'b0 || err_cnt !== 8'd1) begin
      n_fail++; $display("FAIL dir_err_pulse: dir_err=%b err_cnt=%0d expected 0 1", dir_err, err_cnt);
    end
  endtask

  task automatic test_illegal();
    drive(4'd6, 1'b0); drive(4'd5, 1'b0); drive(4'd4, 1'b0);
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL relock_down: locked=%b expected=1", locked);
    end
    drive(4'd3, 1'b0);
    drive(4'd9, 1'b0);
    n_tests++;
    if (step_err !== 1'b1 || dir_err !== 1'b0 || dir_up !== 1'b0 || dir_down !== 1'b0 || err_cnt !== 8'd2 || locked !== 1'b0) begin
      n_fail++; $display("FAIL step_err: step_err=%b dir_err=%b dir_up=%b dir_down=%b err_cnt=%0d locked=%b expected 1 0 0 0 2 0", step_err, dir_err, dir_up, dir_down, err_cnt, locked);
    end
    drive(4'd8, 1'b0);
    n_tests++;
    if (step_err !== 1'b0 || locked !== 1'b0) begin
      n_fail++; $display("FAIL step_err_pulse: step_err=%b locked=%b expected 0 0", step_err, locked);
    end
    drive(4'd7, 1'b0); drive(4'd6, 1'b0);
    n_tests++;
    if (locked !== 1'b0) begin
      n_fail++; $display("FAIL relock_early: locked=%b expected=0", locked);
    end
    drive(4'd5, 1'b0);
    n_tests++;
    if (locked !== 1'b1 || err_cnt !== 8'd2) begin
      n_fail++; $display("FAIL relock_after_err: locked=%b err_cnt=%0d expected 1 2", locked, err_cnt);
    end
  endtask

  task automatic test_hold();
    drive(4'd5, 1'b0);
`ifdef UDMON_STRICT_STEP_EN
    n_tests++;
    if (step_err !== 1'b1 || locked !== 1'b0 || err_cnt !== 8'd3) begin
      n_fail++; $display("FAIL hold_strict: step_err=%b locked=%b err_cnt=%0d expected 1 0 3", step_err, locked, err_cnt);
    end
`else
    n_tests++;
    if (step_err !== 1'b0 || dir_err !== 1'b0 || locked !== 1'b1 || err_cnt !== 8'd2 || dir_down !== 1'b1) begin
      n_fail++; $display("FAIL hold_stall: step_err=%b dir_err=%b locked=%b err_cnt=%0d dir_down=%b expected 0 0 1 2 1", step_err, dir_err, locked, err_cnt, dir_down);
    end
`endif
  endtask

  task automatic test_err_sat();
    logic [3:0] v;
    drive(4'd4, 1'b0); drive(4'd3, 1'b0); drive(4'd2, 1'b0); drive(4'd1, 1'b0);
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_lock: locked=%b expected=1", locked);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({dir_up, dir_down, wrap, step_err, dir_err, locked, err_cnt} !== 14'd0) begin
      n_fail++; $display("FAIL reset_midlock: outputs=%h expected=0", {dir_up, dir_down, wrap, step_err, dir_err, locked, err_cnt});
    end
    @(negedge clk);
    reset = 1'b1; count_in = 4'd0; upordown = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 300; i++) begin
      v = (i % 2 == 0) ? 4'd8 : 4'd0;
      drive(v, 1'b1);
      if (i == 99) begin
        n_tests++;
        if (err_cnt !== 8'd100) begin
          n_fail++; $display("FAIL err_cnt_100: err_cnt=%0d expected=100", err_cnt);
        end
      end
      if (i == 254) begin
        n_tests++;
        if (err_cnt !== 8'd255) begin
          n_fail++; $display("FAIL err_cnt_255: err_cnt=%0d expected=255", err_cnt);
        end
      end
    end
    n_tests++;
    if (err_cnt !== 8'd255 || step_err !== 1'b1) begin
      n_fail++; $display("FAIL err_cnt_sat: err_cnt=%0d step_err=%b expected 255 1", err_cnt, step_err);
    end
    drive(4'd1, 1'b1); drive(4'd2, 1'b1); drive(4'd3, 1'b1);
    n_tests++;
    if (locked !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_early: locked=%b expected=0", locked);
    end
    drive(4'd4, 1'b1);
    n_tests++;
    if (locked !== 1'b1 || err_cnt !== 8'd255) begin
      n_fail++; $display("FAIL post_reset_relock: locked=%b err_cnt=%0d expected 1 255", locked, err_cnt);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_lock();
    test_wrap();
    test_dir();
    test_illegal();
    test_hold();
    test_err_sat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_count_monitor.md
UPDOWN_COUNT_MONITOR -- requirements
Module: updown_count_monitor

Interface
REQ-001 Parameter WIDTH, default 4, width of the observed count bus.
REQ-002 Parameter LOCK_N, default 4, consecutive legal matching steps needed to declare lock; range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 count_in  input  WIDTH  registered output of the observed up/down counter.
REQ-006 upordown  input  1  direction command driven to the observed counter; 1=up, 0=down.
REQ-007 dir_up  output  1  last classified step was +1.
REQ-008 dir_down  output  1  last classified step was -1.
REQ-009 wrap  output  1  one-cycle pulse on max->0 (up) or 0->max (down) step.
REQ-010 step_err  output  1  one-cycle pulse on an illegal step.
REQ-011 dir_err  output  1  one-cycle pulse on a legal step against the expected direction.
REQ-012 locked  output  1  monitor is tracking a conforming counter.
REQ-013 err_cnt  output  8  saturating count of step_err plus dir_err events.

Function
REQ-014 Each edge registers prev <= count_in and dir_q <= upordown; all outputs registered.
REQ-015 delta = (count_in - prev) mod 2^WIDTH; +1 = up step, all-ones = down step, 0 = hold, anything else = illegal.
REQ-016 Up/down step compares against dir_q, not live upordown, matching the counter's one-edge command latency.
REQ-017 States: UNSYNC (no valid prev), ACQUIRE (run < LOCK_N), LOCKED.
REQ-018 UNSYNC: first edge after reset release captures prev only, no classification, -> ACQUIRE with run=0.
REQ-019 ACQUIRE: legal matching step increments run; reaching LOCK_N on that step -> LOCKED and locked=1 at the same edge.
REQ-020 LOCKED: legal matching steps hold state; run saturates at LOCK_N.
REQ-021 Illegal step: step_err=1, dir_up=dir_down=0; any state other than UNSYNC -> ACQUIRE, run=0, locked=0.
REQ-022 Direction mismatch: dir_err=1, dir_up/dir_down show the observed step, -> ACQUIRE, run=0, locked=0.
REQ-023 step_err and dir_err are mutually exclusive; the same edge increments err_cnt by exactly 1; err_cnt holds at 255.
REQ-024 wrap is asserted only with a legal step, whether matching or mismatched.
REQ-025 With WIDTH=1, +1 and -1 coincide; such a step is classified as matching dir_q.

Reset
REQ-026 reset low: state=UNSYNC, run=0, prev=0, dir_q=0, and all outputs 0 immediately, independent of clk.
REQ-027 Reset asserted mid-lock discards history; re-lock requires LOCK_N fresh steps after release.

Configuration
REQ-028 Macro UDMON_STRICT_STEP_EN defined: a hold (delta 0) in ACQUIRE or LOCKED is treated as illegal (step_err, err_cnt+1, lock drop).
REQ-029 Macro undefined: a hold is a legal stall; no flag; run, state, dir_up and dir_down are unchanged.

Structure
REQ-030 Package udmon_pkg holds the state enum (UNSYNC/ACQUIRE/LOCKED), the step-class enum (UP/DOWN/HOLD/ILLEGAL) and the ERR_CNT_W=8 constant.
REQ-031 Sub-module udmon_step_classify: combinational; inputs prev and count_in; outputs step class and wrap flag; parameterized by WIDTH.

Verification (WIDTH=4, LOCK_N=4)
REQ-032 Release reset, upordown=1, count_in 0,1,2,3,4,5 -> locked rises on the edge sampling 4; dir_up=1; err_cnt=0.
REQ-033 Locked up, count_in 14,15,0,1 -> wrap pulses one cycle on 15->0; no errors; locked stays 1.
REQ-034 Locked up, upordown 1->0 one edge before count_in 7,8,7 -> no dir_err; dir_down=1 on 8->7; a 7->8 with dir_q=0 -> dir_err, err_cnt=1, locked=0.
REQ-035 Locked, count_in 3 then 9 -> step_err one cycle, err_cnt+1, locked=0; four further legal steps re-lock.
REQ-036 Locked, count_in 5,5 -> macro defined: step_err, locked=0; undefined: no flag, locked=1.
REQ-037 reset low mid-lock, then 300 forced errors -> outputs 0 during reset; err_cnt stops at 255.
